// File: rtl/hazard_stall_controller_if.sv
// Pipeline-to-sequencer bundle: hazard/busywait status in, per-stage hold/flush controls and perf counters out.
// master = pipeline datapath side, slave = hazard_stall_controller.
interface hazard_stall_controller_if #(
  parameter int CNT_W = 32
);
  logic             IMEM_BUSYWAIT;
  logic             DMEM_BUSYWAIT;
  logic [4:0]       ID_RS1;
  logic [4:0]       ID_RS2;
  logic             ID_USES_RS1;
  logic             ID_USES_RS2;
  logic [4:0]       EX_RD;
  logic             EX_MEM_READ;
  logic             EX_BRANCH_TAKEN;
  logic             EX_MULDIV_START;
  logic             PC_WRITE;
  logic             IF_ID_HOLD;
  logic             IF_ID_FLUSH;
  logic             ID_EX_HOLD;
  logic             ID_EX_FLUSH;
  logic             EX_MEM_HOLD;
  logic             EX_MEM_FLUSH;
  logic [CNT_W-1:0] STALL_CYCLES;
  logic [CNT_W-1:0] FLUSH_COUNT;

  modport master (
    output IMEM_BUSYWAIT, DMEM_BUSYWAIT, ID_RS1, ID_RS2, ID_USES_RS1, ID_USES_RS2,
           EX_RD, EX_MEM_READ, EX_BRANCH_TAKEN, EX_MULDIV_START,
    input  PC_WRITE, IF_ID_HOLD, IF_ID_FLUSH, ID_EX_HOLD, ID_EX_FLUSH,
           EX_MEM_HOLD, EX_MEM_FLUSH, STALL_CYCLES, FLUSH_COUNT
  );

  modport slave (
    input  IMEM_BUSYWAIT, DMEM_BUSYWAIT, ID_RS1, ID_RS2, ID_USES_RS1, ID_USES_RS2,
           EX_RD, EX_MEM_READ, EX_BRANCH_TAKEN, EX_MULDIV_START,
    output PC_WRITE, IF_ID_HOLD, IF_ID_FLUSH, ID_EX_HOLD, ID_EX_FLUSH,
           EX_MEM_HOLD, EX_MEM_FLUSH, STALL_CYCLES, FLUSH_COUNT
  );
endinterface

// File: rtl/hazard_stall_controller.sv
// RV32IM 5-stage sequencer: per-cycle advance/hold/bubble decisions plus saturating stall/flush counters.
// Controls are zero-latency combinational; DMEM busywait freezes everything, including the FSM.
module hazard_stall_controller #(
  parameter int MULDIV_LAT = 32,
  parameter int CNT_W      = 32
) (
  input  logic                     CLK,
  input  logic                     RESET,
  hazard_stall_controller_if.slave bus
);

  localparam int CW       = $clog2(MULDIV_LAT) + 1;
  localparam int CNT_LOAD = (MULDIV_LAT > 1) ? MULDIV_LAT - 2 : 0;

  typedef enum logic [1:0] {RUN, MULDIV, DISCARD} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             load_use;
  logic             flush_evt;
  logic             pc_write, if_id_hold, if_id_flush;
  logic             id_ex_hold, id_ex_flush, ex_mem_hold, ex_mem_flush;
  logic [CNT_W-1:0] stall_cycles, flush_count;

  always_comb begin
    load_use = bus.EX_MEM_READ && (bus.EX_RD != 5'd0) &&
               ((bus.ID_USES_RS1 && (bus.ID_RS1 == bus.EX_RD)) ||
                (bus.ID_USES_RS2 && (bus.ID_RS2 == bus.EX_RD)));
  end

  always_comb begin
    pc_write     = 1'b1;
    if_id_hold   = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_hold   = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_hold  = 1'b0;
    ex_mem_flush = 1'b0;
    flush_evt    = 1'b0;
    state_nxt    = state;
    cnt_nxt      = cnt;
    if (bus.DMEM_BUSYWAIT) begin
      pc_write    = 1'b0;
      if_id_hold  = 1'b1;
      id_ex_hold  = 1'b1;
      ex_mem_hold = 1'b1;
    end else begin
      case (state)
        RUN: begin
          if (bus.EX_BRANCH_TAKEN) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            flush_evt   = 1'b1;
            if (bus.IMEM_BUSYWAIT) state_nxt = DISCARD;
          end else if (bus.EX_MULDIV_START && (MULDIV_LAT > 1)) begin
            pc_write     = 1'b0;
            if_id_hold   = 1'b1;
            id_ex_hold   = 1'b1;
            ex_mem_flush = 1'b1;
            cnt_nxt      = CW'(CNT_LOAD);
            state_nxt    = MULDIV;
          end else if (load_use) begin
            pc_write    = 1'b0;
            if_id_hold  = 1'b1;
            id_ex_flush = 1'b1;
          end else if (bus.IMEM_BUSYWAIT) begin
            pc_write    = 1'b0;
            if_id_flush = 1'b1;
          end
        end
        MULDIV: begin
          if (cnt != '0) begin
            pc_write     = 1'b0;
            if_id_hold   = 1'b1;
            id_ex_hold   = 1'b1;
            ex_mem_flush = 1'b1;
            cnt_nxt      = cnt - CW'(1);
          end else begin
            // final occupancy cycle: result latches into EX/MEM with defaults
            state_nxt = RUN;
          end
        end
        DISCARD: begin
          pc_write    = 1'b0;
          if_id_flush = 1'b1;
          if (!bus.IMEM_BUSYWAIT) state_nxt = RUN;
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state        <= RUN;
      cnt          <= '0;
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (!pc_write && !(&stall_cycles)) stall_cycles <= stall_cycles + CNT_W'(1);
      if (flush_evt && !(&flush_count))  flush_count  <= flush_count + CNT_W'(1);
    end
  end

  assign bus.PC_WRITE     = pc_write;
  assign bus.IF_ID_HOLD   = if_id_hold;
  assign bus.IF_ID_FLUSH  = if_id_flush;
  assign bus.ID_EX_HOLD   = id_ex_hold;
  assign bus.ID_EX_FLUSH  = id_ex_flush;
  assign bus.EX_MEM_HOLD  = ex_mem_hold;
  assign bus.EX_MEM_FLUSH = ex_mem_flush;
  assign bus.STALL_CYCLES = stall_cycles;
  assign bus.FLUSH_COUNT  = flush_count;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Bench for hazard_stall_controller: directed scenarios plus randomized traffic vs. a cycle-occupancy reference model.
module tb_hazard_stall_controller;

  localparam int LAT    = 4;
  localparam int CW     = 4;
  localparam int SATMAX = (1 << CW) - 1;

  // control vector order: PC_WRITE, IF_ID_HOLD, IF_ID_FLUSH, ID_EX_HOLD, ID_EX_FLUSH, EX_MEM_HOLD, EX_MEM_FLUSH
  localparam logic [6:0] C_DEF = 7'b1000000;
  localparam logic [6:0] C_LU  = 7'b0100100;
  localparam logic [6:0] C_MD  = 7'b0101001;
  localparam logic [6:0] C_FRZ = 7'b0101010;
  localparam logic [6:0] C_BR  = 7'b1010100;
  localparam logic [6:0] C_IMF = 7'b0010000;

  logic CLK = 1'b0;
  logic RESET;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 CLK = ~CLK;

  hazard_stall_controller_if #(.CNT_W(CW)) hz ();

  hazard_stall_controller #(.MULDIV_LAT(LAT), .CNT_W(CW)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (hz)
  );

  function automatic logic [6:0] ctl();
    return {hz.PC_WRITE, hz.IF_ID_HOLD, hz.IF_ID_FLUSH, hz.ID_EX_HOLD,
            hz.ID_EX_FLUSH, hz.EX_MEM_HOLD, hz.EX_MEM_FLUSH};
  endfunction

  // Reference model: tracks remaining EX occupancy of a mul/div op and whether a stale fetch is pending.
  int         m_ex_left, m_stall, m_flush;
  bit         m_discard;
  logic [6:0] e_ctl;
  logic       e_br;
  int         e_stall, e_flush;

  always_comb begin
    logic hazard;
    hazard = hz.EX_MEM_READ && (hz.EX_RD != 0) &&
             ((hz.ID_USES_RS1 && hz.ID_RS1 == hz.EX_RD) || (hz.ID_USES_RS2 && hz.ID_RS2 == hz.EX_RD));
    e_br  = 1'b0;
    e_ctl = C_DEF;
    if (hz.DMEM_BUSYWAIT)            e_ctl = C_FRZ;
    else if (m_discard)              e_ctl = C_IMF;
    else if (m_ex_left > 1)          e_ctl = C_MD;
    else if (m_ex_left == 1)         e_ctl = C_DEF;
    else if (hz.EX_BRANCH_TAKEN)     begin e_ctl = C_BR; e_br = 1'b1; end
    else if (hz.EX_MULDIV_START)     e_ctl = C_MD;
    else if (hazard)                 e_ctl = C_LU;
    else if (hz.IMEM_BUSYWAIT)       e_ctl = C_IMF;
    e_stall = (m_stall > SATMAX) ? SATMAX : m_stall;
    e_flush = (m_flush > SATMAX) ? SATMAX : m_flush;
  end

  always @(posedge CLK) begin
    if (RESET) begin
      m_ex_left <= 0;
      m_stall   <= 0;
      m_flush   <= 0;
      m_discard <= 1'b0;
    end else begin
      if (!e_ctl[6]) m_stall <= m_stall + 1;
      if (e_br)      m_flush <= m_flush + 1;
      if (!hz.DMEM_BUSYWAIT) begin
        if (m_discard)                m_discard <= hz.IMEM_BUSYWAIT;
        else if (m_ex_left > 0)       m_ex_left <= m_ex_left - 1;
        else if (hz.EX_BRANCH_TAKEN)  m_discard <= hz.IMEM_BUSYWAIT;
        else if (hz.EX_MULDIV_START)  m_ex_left <= LAT - 1;
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    hz.IMEM_BUSYWAIT   = 1'b0;
    hz.DMEM_BUSYWAIT   = 1'b0;
    hz.ID_RS1          = 5'd0;
    hz.ID_RS2          = 5'd0;
    hz.ID_USES_RS1     = 1'b0;
    hz.ID_USES_RS2     = 1'b0;
    hz.EX_RD           = 5'd0;
    hz.EX_MEM_READ     = 1'b0;
    hz.EX_BRANCH_TAKEN = 1'b0;
    hz.EX_MULDIV_START = 1'b0;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    clear_inputs();
    tick();
    RESET = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    clear_inputs();
    tick();
    tick();
    @(negedge CLK);
    n_checks++;
    if (ctl() !== C_DEF) begin n_fail++; $display("FAIL reset_ctl got %b want %b", ctl(), C_DEF); end
    n_checks++;
    if (hz.STALL_CYCLES !== 4'd0) begin n_fail++; $display("FAIL reset_stall got %0d want 0", hz.STALL_CYCLES); end
    n_checks++;
    if (hz.FLUSH_COUNT !== 4'd0) begin n_fail++; $display("FAIL reset_flush got %0d want 0", hz.FLUSH_COUNT); end
    tick();
    RESET = 1'b0;
  endtask

  task automatic test_load_use();
    do_reset();
    hz.EX_MEM_READ = 1'b1; hz.EX_RD = 5'd5;
    hz.ID_RS2 = 5'd5; hz.ID_USES_RS2 = 1'b1; hz.ID_RS1 = 5'd7; hz.ID_USES_RS1 = 1'b1;
    @(negedge CLK);
    n_checks++;
    if (ctl() !== C_LU) begin n_fail++; $display("FAIL loaduse_stall got %b want %b", ctl(), C_LU); end
    tick();
    clear_inputs();
    @(negedge CLK);
    n_checks++;
    if (ctl() !== C_DEF) begin n_fail++; $display("FAIL loaduse_release got %b want %b", ctl(), C_DEF); end
    n_checks++;
    if (hz.STALL_CYCLES !== 4'd1) begin n_fail++; $display("FAIL loaduse_count got %0d want 1", hz.STALL_CYCLES); end
    hz.EX_MEM_READ = 1'b1; hz.EX_RD = 5'd0; hz.ID_RS2 = 5'd0; hz.ID_USES_RS2 = 1'b1;
    @(negedge CLK);
    n_checks++;
    if (ctl() !== C_DEF) begin n_fail++; $display("FAIL loaduse_x0 got %b want %b", ctl(), C_DEF); end
    hz.EX_RD = 5'd5; hz.ID_RS1 = 5'd5; hz.ID_USES_RS1 = 1'b0; hz.ID_RS2 = 5'd3;
    @(negedge CLK);
    n_checks++;
    if (ctl() !== C_DEF) begin n_fail++; $display("FAIL loaduse_unused_rs got %b want %b", ctl(), C_DEF); end
    hz.ID_USES_RS1 = 1'b1;
    @(negedge CLK);
    n_checks++;
    if (ctl() !== C_LU) begin n_fail++; $display("FAIL loaduse_rs1 got %b want %b", ctl(), C_LU); end
    tick();
    clear_inputs();
  endtask

  task automatic test_muldiv();
    do_reset();
    hz.EX_MULDIV_START = 1'b1;
    for (int i = 0; i < LAT; i++) begin
      @(negedge CLK);
      n_checks++;
      if (ctl() !== ((i == LAT - 1) ? C_DEF : C_MD)) begin
        n_fail++; $display("FAIL muldiv_cycle%0d got %b want %b", i, ctl(), (i == LAT - 1) ? C_DEF : C_MD);
      end
      tick();
      hz.EX_MULDIV_START = 1'b0;
    end
    @(negedge CLK);
    n_checks++;
    if (hz.STALL_CYCLES !== 4'd3) begin n_fail++; $display("FAIL muldiv_stall got %0d want 3", hz.STALL_CYCLES); end
  endtask

  task automatic test_muldiv_freeze();
    logic [6:0] exp_seq [6] = '{C_MD, C_MD, C_FRZ, C_FRZ, C_MD, C_DEF};
    logic       dmem_seq [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      hz.EX_MULDIV_START = (i == 0);
      hz.DMEM_BUSYWAIT   = dmem_seq[i];
      @(negedge CLK);
      n_checks++;
      if (ctl() !== exp_seq[i]) begin n_fail++; $display("FAIL mdfreeze_cycle%0d got %b want %b", i, ctl(), exp_seq[i]); end
      tick();
    end
    clear_inputs();
    @(negedge CLK);
    n_checks++;
    if (hz.STALL_CYCLES !== 4'd5) begin n_fail++; $display("FAIL mdfreeze_stall got %0d want 5", hz.STALL_CYCLES); end
  endtask

  task automatic test_branch_discard();
    do_reset();
    hz.EX_BRANCH_TAKEN = 1'b1; hz.IMEM_BUSYWAIT = 1'b1;
    @(negedge CLK);
    n_checks++;
    if (ctl() !== C_BR) begin n_fail++; $display("FAIL branch_first got %b want %b", ctl(), C_BR); end
    tick();
    for (int i = 1; i < 4; i++) begin
      hz.EX_BRANCH_TAKEN = (i == 1);
      hz.IMEM_BUSYWAIT   = (i < 3);
      @(negedge CLK);
      n_checks++;
      if (ctl() !== C_IMF) begin n_fail++; $display("FAIL discard_cycle%0d got %b want %b", i, ctl(), C_IMF); end
      tick();
    end
    clear_inputs();
    @(negedge CLK);
    n_checks++;
    if (ctl() !== C_DEF) begin n_fail++; $display("FAIL discard_exit got %b want %b", ctl(), C_DEF); end
    n_checks++;
    if (hz.FLUSH_COUNT !== 4'd1) begin n_fail++; $display("FAIL branch_flushcount got %0d want 1", hz.FLUSH_COUNT); end
    n_checks++;
    if (hz.STALL_CYCLES !== 4'd3) begin n_fail++; $display("FAIL discard_stall got %0d want 3", hz.STALL_CYCLES); end
  endtask

  task automatic test_branch_loaduse();
    do_reset();
    hz.EX_BRANCH_TAKEN = 1'b1; hz.EX_MEM_READ = 1'b1; hz.EX_RD = 5'd9;
    hz.ID_RS1 = 5'd9; hz.ID_USES_RS1 = 1'b1;
    @(negedge CLK);
    n_checks++;
    if (ctl() !== C_BR) begin n_fail++; $display("FAIL branch_vs_loaduse got %b want %b", ctl(), C_BR); end
    tick();
    clear_inputs();
    @(negedge CLK);
    n_checks++;
    if (hz.STALL_CYCLES !== 4'd0) begin n_fail++; $display("FAIL branch_vs_loaduse_stall got %0d want 0", hz.STALL_CYCLES); end
  endtask

  task automatic test_saturation();
    do_reset();
    hz.IMEM_BUSYWAIT = 1'b1;
    @(negedge CLK);
    n_checks++;
    if (ctl() !== C_IMF) begin n_fail++; $display("FAIL imem_stall got %b want %b", ctl(), C_IMF); end
    repeat (20) tick();
    @(negedge CLK);
    n_checks++;
    if (hz.STALL_CYCLES !== 4'd15) begin n_fail++; $display("FAIL stall_saturate got %0d want 15", hz.STALL_CYCLES); end
    clear_inputs();
  endtask

  task automatic test_reset_discard();
    do_reset();
    hz.EX_BRANCH_TAKEN = 1'b1; hz.IMEM_BUSYWAIT = 1'b1;
    tick();
    hz.EX_BRANCH_TAKEN = 1'b0;
    @(negedge CLK);
    n_checks++;
    if (ctl() !== C_IMF) begin n_fail++; $display("FAIL rstdisc_in_discard got %b want %b", ctl(), C_IMF); end
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    hz.EX_BRANCH_TAKEN = 1'b1; hz.IMEM_BUSYWAIT = 1'b0;
    @(negedge CLK);
    n_checks++;
    if (ctl() !== C_BR) begin n_fail++; $display("FAIL rstdisc_state got %b want %b", ctl(), C_BR); end
    n_checks++;
    if (hz.STALL_CYCLES !== 4'd0 || hz.FLUSH_COUNT !== 4'd0) begin
      n_fail++; $display("FAIL rstdisc_counters got %0d/%0d want 0/0", hz.STALL_CYCLES, hz.FLUSH_COUNT);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      RESET              = ($urandom_range(0, 63) == 0);
      hz.DMEM_BUSYWAIT   = ($urandom_range(0, 5) == 0);
      hz.IMEM_BUSYWAIT   = ($urandom_range(0, 3) == 0);
      hz.EX_BRANCH_TAKEN = ($urandom_range(0, 7) == 0);
      hz.EX_MULDIV_START = ($urandom_range(0, 7) == 0);
      hz.EX_MEM_READ     = $urandom_range(0, 1);
      hz.EX_RD           = 5'($urandom_range(0, 3));
      hz.ID_RS1          = 5'($urandom_range(0, 3));
      hz.ID_RS2          = 5'($urandom_range(0, 3));
      hz.ID_USES_RS1     = $urandom_range(0, 1);
      hz.ID_USES_RS2     = $urandom_range(0, 1);
      @(negedge CLK);
      n_checks++;
      if (ctl() !== e_ctl) begin
        n_fail++;
        if (n_fail < 20) $display("FAIL rand_ctl cyc%0d got %b want %b", i, ctl(), e_ctl);
      end
      n_checks++;
      if (hz.STALL_CYCLES !== 4'(e_stall) || hz.FLUSH_COUNT !== 4'(e_flush)) begin
        n_fail++;
        if (n_fail < 20) $display("FAIL rand_cnt cyc%0d got %0d/%0d want %0d/%0d",
                                  i, hz.STALL_CYCLES, hz.FLUSH_COUNT, e_stall, e_flush);
      end
      n_checks++;
      if ((hz.IF_ID_HOLD && hz.IF_ID_FLUSH) || (hz.ID_EX_HOLD && hz.ID_EX_FLUSH) ||
          (hz.EX_MEM_HOLD && hz.EX_MEM_FLUSH)) begin
        n_fail++;
        if (n_fail < 20) $display("FAIL rand_hold_flush cyc%0d got %b want no hold+flush pair", i, ctl());
      end
      tick();
    end
    RESET = 1'b0;
    clear_inputs();
  endtask

  initial begin
    RESET = 1'b1;
    clear_inputs();
    test_reset();
    test_load_use();
    test_muldiv();
    test_muldiv_freeze();
    test_branch_discard();
    test_branch_loaduse();
    test_saturation();
    test_reset_discard();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_stall_controller.md
# hazard_stall_controller

Central pipeline sequencing block for the RV32IM 5-stage core. Each cycle it decides whether PC, IF/ID, ID/EX and EX/MEM advance, hold or take a bubble. Inputs are instruction-memory and data-memory busywait, load-use hazards, taken branches/jumps and multi-cycle M-extension ops in EX. It also keeps saturating stall and flush counters for performance debug.

## Interface
- MULDIV_LAT, default 32: total EX-stage occupancy in cycles of a MUL/DIV op; must be ≥1.
- CNT_W, default 32: width of the performance counters.

Ports:
- CLK  in  1  clock
- RESET  in  1  reset RESET, synchronous, active-high; clock CLK
- IMEM_BUSYWAIT  in  1  instruction fetch not complete
- DMEM_BUSYWAIT  in  1  data memory access not complete
- ID_RS1, ID_RS2  in  5 each  source registers of the instruction in ID
- ID_USES_RS1, ID_USES_RS2  in  1 each  ID instruction actually reads that source
- EX_RD  in  5  destination register of the instruction in EX
- EX_MEM_READ  in  1  EX instruction is a load
- EX_BRANCH_TAKEN  in  1  EX resolved a taken branch/jump; PC input carries the target
- EX_MULDIV_START  in  1  EX holds a valid MUL/DIV op
- PC_WRITE  out  1  PC loads its next value
- IF_ID_HOLD, IF_ID_FLUSH  out  1 each  IF/ID keeps contents / loads NOP
- ID_EX_HOLD, ID_EX_FLUSH  out  1 each  ID/EX keeps contents / loads NOP
- EX_MEM_HOLD  out  1  drives EX/MEM BUSYWAIT (freeze); MEM/WB uses the same signal
- EX_MEM_FLUSH  out  1  EX/MEM loads bubble (all control bits 0)
- STALL_CYCLES  out  CNT_W  cycles with PC_WRITE=0
- FLUSH_COUNT  out  CNT_W  accepted taken branches

## Operation
- FSM states: RUN, MULDIV, DISCARD. A down-counter CNT (width clog2(MULDIV_LAT)+1) is used in MULDIV.
- Control outputs are combinational from state and inputs. Default: PC_WRITE=1, all other controls 0.
- FREEZE has priority in every state: DMEM_BUSYWAIT=1 sets EX_MEM_HOLD=1, ID_EX_HOLD=1, IF_ID_HOLD=1, PC_WRITE=0 and no flushes. State and CNT do not change during FREEZE.
- RUN, without FREEZE, applies the first matching rule in this order:
  1. EX_BRANCH_TAKEN: PC_WRITE=1, IF_ID_FLUSH=1, ID_EX_FLUSH=1, FLUSH_COUNT+1. If IMEM_BUSYWAIT=1, go to DISCARD.
  2. EX_MULDIV_START with MULDIV_LAT>1: PC_WRITE=0, IF_ID_HOLD=1, ID_EX_HOLD=1, EX_MEM_FLUSH=1. Load CNT=MULDIV_LAT-2 and go to MULDIV. With MULDIV_LAT=1 the op is treated as a normal instruction.
  3. Load-use hazard: EX_MEM_READ=1, EX_RD≠0, and (ID_USES_RS1 and ID_RS1==EX_RD, or ID_USES_RS2 and ID_RS2==EX_RD). Action: PC_WRITE=0, IF_ID_HOLD=1, ID_EX_FLUSH=1.
  4. IMEM_BUSYWAIT: PC_WRITE=0, IF_ID_FLUSH=1.
- MULDIV state:
  - If CNT≠0, apply the same holds and bubble as rule 2 and decrement CNT.
  - If CNT==0, apply defaults (result latches into EX/MEM) and go to RUN.
- DISCARD state: PC_WRITE=0 and IF_ID_FLUSH=1 every cycle, so the stale fetch is dropped. On the first cycle with IMEM_BUSYWAIT=0, go to RUN. EX_BRANCH_TAKEN is ignored in this state.
- Invariant: HOLD and FLUSH are never both 1 for the same register.
- Counters are registered and saturate at all-ones:
  - STALL_CYCLES increments on every posedge where PC_WRITE=0.
  - FLUSH_COUNT increments on every rule-1 event.
- Reset values: state RUN, CNT=0, STALL_CYCLES=0, FLUSH_COUNT=0. The combinational outputs then show RUN defaults for the current inputs.

## Timing
- Control outputs have zero latency: they are valid in the same cycle as their inputs and are sampled by the pipeline registers at the next posedge CLK.
- Load-use inserts exactly 1 bubble.
- A MUL/DIV op occupies EX for exactly MULDIV_LAT non-frozen cycles, with MULDIV_LAT-1 bubbles into MEM.
- A taken branch costs 2 flushed slots, plus the DISCARD cycles if IMEM is busy.
- RESET asserted mid-MULDIV or mid-DISCARD returns to RUN at that edge. Counters clear and no pending state survives.
- A branch arriving simultaneously with IMEM_BUSYWAIT takes the branch rule; the IMEM rule is not applied in that cycle.

## Test plan
- Load-use: EX holds a load with EX_RD=5 and ID_RS2=5, ID_USES_RS2=1 → one cycle of PC_WRITE=0, IF_ID_HOLD=1, ID_EX_FLUSH=1, then defaults; STALL_CYCLES=1. Repeat with EX_RD=0 → no stall.
- MUL/DIV with MULDIV_LAT=4: EX_MULDIV_START for one cycle → holds for 3 cycles, EX_MEM_FLUSH high for 3 cycles, release on cycle 4; STALL_CYCLES=3.
- DMEM_BUSYWAIT high for 2 cycles in the middle of MULDIV → all holds asserted, CNT frozen; total muldiv span becomes 6 cycles.
- Taken branch with IMEM_BUSYWAIT=1 for 3 cycles → first cycle flushes IF/ID and ID/EX with PC_WRITE=1; DISCARD asserts IF_ID_FLUSH through the cycle IMEM_BUSYWAIT drops; FLUSH_COUNT=1.
- Branch and load-use hazard in the same cycle → branch rule only, no hold.
- Counter saturation with CNT_W=4 → STALL_CYCLES stops at 15. RESET asserted during DISCARD → RUN, both counters 0 on the next cycle.
